mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store initiator for the multi-cycle core's unified instruction/data memory. Takes one byte-addressed load or store request at a time from the core datapath and drives the word-addressed memory port. Sub-word stores (SB/SH) become a read-modify-write sequence because the memory writes whole words only. Loads return a sign- or zero-extended result.

## Interface
- `MEM_WORDS`, 128: memory depth in 32-bit words; word index width is `$clog2(MEM_WORDS)`.
- `i_Clk` in 1: clock, rising edge.
- `i_Reset` in 1: asynchronous, active-low reset.
- `i_Req` in 1: request strobe; accepted only in IDLE.
- `i_We` in 1: 1 = store, 0 = load.
- `i_Funct3` in 3: RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `i_Addr` in 32: byte address.
- `i_wData` in 32: store data; the low byte or halfword is used for SB/SH.
- `o_Busy` out 1: high from the cycle after acceptance until the cycle after `o_Done`.
- `o_Done` out 1: one-cycle completion pulse.
- `o_Err` out 1: valid with `o_Done`; misaligned or out-of-range request.
- `o_rData` out 32: load result; valid with `o_Done` and held until the next acceptance.
- `o_MemAdrSrc` out 1: driven 1 for the whole access (word-index addressing).
- `o_MemAddr` out 32: word index, `addr[31:2]`.
- `o_MemWE` out 1: memory write enable.
- `o_MemWData` out 32: memory write data.
- `i_MemRData` in 32: combinational memory read data.

## Operation
- **FSM states:** IDLE, RD, WR, RESP.
- **IDLE:**
  - `i_Req` = 1 registers addr, funct3, we and wdata.
  - Next state is RD for loads and SB/SH, WR for SW.
  - If an error is detected, go straight to RESP with `o_Err` = 1.
- **RD:** drive the memory address and capture `i_MemRData` into the read buffer at the clock edge.
  - Loads go to RESP.
  - SB/SH go to WR.
- **WR:** `o_MemWE` = 1.
  - SW writes `i_wData` unchanged.
  - SB/SH write the read buffer with the selected lane replaced. The lane is `addr[1:0]` for bytes and `addr[1]` for halfwords; all other lanes are preserved.
  - Next state is RESP.
- **RESP:** `o_Done` = 1, then return to IDLE.
- **Load result:** the selected lane is extracted from the read buffer.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes all 32 bits.
- **Error conditions** (no memory access; `o_MemWE` stays 0; `o_rData` unchanged):
  - Word index ≥ `MEM_WORDS`.
  - Any store to a word index < `MEM_WORDS/2` (instruction half).
  - Undefined funct3, e.g. 3'b011.
  - Misalignment (see Configuration).
- **Busy/request rules:**
  - `i_Req` while busy is ignored and not queued.
  - `i_Req` in the RESP→IDLE cycle is not accepted; the earliest new acceptance is the cycle after `o_Done`.
- **Reset:** asynchronous; takes effect mid-operation immediately.
  - State returns to IDLE; an in-flight write is abandoned.
  - `o_MemWE`, `o_Done`, `o_Err` and `o_Busy` go to 0 immediately.
  - `o_rData`, `o_MemAddr`, `o_MemWData` and the read buffer reset to 0.
  - `o_MemAdrSrc` resets to 1.

## Timing
Cycle 0 is the acceptance edge.
- **Load:** RD in cycle 1, `o_Done` in cycle 2. Latency 2.
- **SW:** WR in cycle 1 (write commits at the end of cycle 1), `o_Done` in cycle 2. Latency 2.
- **SB/SH:** RD in cycle 1, WR in cycle 2, `o_Done` in cycle 3. Latency 3.
- **Error:** `o_Done` + `o_Err` in cycle 1. Latency 1.
- **Output registering:** `o_MemWE` and `o_MemWData` are registered (Moore) outputs of WR; `o_MemAddr` is stable from RD/WR entry through RESP.
- **Throughput:** back-to-back requests are accepted every 3 cycles (word) or 4 cycles (sub-word).

## Configuration
- **`MEM_ACCESS_ALIGN_CHECK_EN` defined:**
  - LH/LHU/SH with `addr[0]` = 1 → error.
  - LW/SW with `addr[1:0]` ≠ 0 → error.
- **Undefined:**
  - No alignment error; offset bits that the width does not use are ignored.
  - LW/SW at byte address 0x103 accesses word 0x40.
  - LH/LHU/SH use lane `addr[1]`.
- The range and instruction-half protection checks apply in both builds.

## Structure
- **Package `mem_access_pkg`:**
  - State enum: IDLE/RD/WR/RESP.
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - A lane-select helper function.
- **Sub-module `mem_lane_unit`** (combinational):
  - Store merge: read word, new data, funct3, offset → merged word.
  - Load extract/extend: read word, funct3, offset → result.
  - It is instantiated once; the FSM and registers stay in `mem_access_ctrl`.

## Test plan
- **LB sign-extend:** memory word 0x40 = 0x80FF7F01, LB addr 0x102 → `o_rData` = 0xFFFFFFFF, `o_Done` in cycle 2. LBU at the same address → 0x000000FF.
- **SB read-modify-write:** memory word 0x41 = 0x11223344, SB addr 0x105, wdata 0xAB → word becomes 0x1122AB44. Exactly one `o_MemWE` cycle (cycle 2), `o_Done` in cycle 3.
- **SW to instruction half:** SW addr 0x010 → `o_Done` + `o_Err` in cycle 1, `o_MemWE` never asserted, word 0x04 unchanged.
- **Misaligned LW at 0x102:**
  - With the macro: `o_Err` = 1.
  - Without it: returns word 0x40, `o_Err` = 0.
- **Reset mid-operation:** `i_Reset` low during the WR cycle of an SH → all outputs return to reset values immediately. After release, an LW to that word returns its old value, and a new request is accepted on the next clock edge.
- **Request while busy:** `i_Req` pulsed in cycle 1 of a load → ignored; a single `o_Done`; the next request is accepted only after `o_Busy` falls.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store initiator: FSM states, RV32I
// width codes and the byte-lane selector used by both merge and extract paths.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // First byte lane touched by an access: bytes use the full offset,
  // halfwords only addr[1], words always start at lane 0.
  function automatic logic [1:0] lane_sel(input logic [1:0] size,
                                          input logic [1:0] offset);
    case (size)
      2'b00:   return offset;
      2'b01:   return {offset[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: merges sub-word store data into a read word and
// extracts/extends a load result from a read word.
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  always_comb begin
    lane      = lane_sel(funct3[1:0], offset);
    shifted   = rd_word >> {lane, 3'b000};
    merged    = wr_data;
    load_data = rd_word;
    case (funct3[1:0])
      2'b00: begin
        merged = rd_word;
        case (lane)
          2'd0:    merged[7:0]   = wr_data[7:0];
          2'd1:    merged[15:8]  = wr_data[7:0];
          2'd2:    merged[23:16] = wr_data[7:0];
          default: merged[31:24] = wr_data[7:0];
        endcase
        load_data = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        merged = rd_word;
        if (lane[1]) merged[31:16] = wr_data[15:0];
        else         merged[15:0]  = wr_data[15:0];
        load_data = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        merged    = wr_data;
        load_data = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the unified word-addressed memory; sub-word stores
// run as read-modify-write. Optional alignment checking: MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 128
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Req,
  input  logic        i_We,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_wData,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Err,
  output logic [31:0] o_rData,
  output logic        o_MemAdrSrc,
  output logic [31:0] o_MemAddr,
  output logic        o_MemWE,
  output logic [31:0] o_MemWData,
  input  logic [31:0] i_MemRData,
  output state_t      o_State
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_t             state, next_state;
  logic               accept;
  logic               req_err, f3_ok, range_ok, prot_ok, align_ok;
  logic [29:0]        word_idx;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic               we_q, err_q;
  logic [31:0]        wdata_q, rbuf, rdata_q, mem_wdata_q;
  logic [IDX_W-1:0]   mem_idx_q;
  logic               mem_we_q, adr_src_q;
  logic [31:0]        lane_word, merged, load_data;

  // Request checks are evaluated on the live inputs so an error can skip
  // straight to RESP without touching memory.
  always_comb begin
    word_idx = i_Addr[31:2];
    range_ok = (word_idx < 30'(MEM_WORDS));
    prot_ok  = !(i_We && (word_idx < 30'(MEM_WORDS / 2)));
    if (i_We) f3_ok = (i_Funct3 == F3_B) || (i_Funct3 == F3_H) || (i_Funct3 == F3_W);
    else      f3_ok = (i_Funct3 == F3_B) || (i_Funct3 == F3_H) || (i_Funct3 == F3_W) ||
                      (i_Funct3 == F3_BU) || (i_Funct3 == F3_HU);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    case (i_Funct3[1:0])
      2'b01:   align_ok = !i_Addr[0];
      2'b10:   align_ok = (i_Addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
`else
    align_ok = 1'b1;
`endif
    req_err = !(f3_ok && range_ok && prot_ok && align_ok);
  end

  // Handshake: i_Req is a one-cycle strobe sampled only in IDLE; anything
  // presented while busy (including the RESP cycle) is dropped, not queued.
  // o_Done pulses for one cycle in RESP with o_Err/o_rData valid alongside.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (i_Req) begin
        accept = 1'b1;
        if (req_err)                         next_state = RESP;
        else if (i_We && i_Funct3 == F3_W)   next_state = WR;
        else                                 next_state = RD;
      end
      RD:      next_state = we_q ? WR : RESP;
      WR:      next_state = RESP;
      default: next_state = IDLE;
    endcase
  end

  // In RD the lane unit sees the word being captured, so the merged store
  // word and load result are ready at the same edge that fills rbuf.
  assign lane_word = (state == RD) ? i_MemRData : rbuf;

  mem_lane_unit u_lane (
    .rd_word   (lane_word),
    .wr_data   (wdata_q),
    .funct3    (f3_q),
    .offset    (off_q),
    .merged    (merged),
    .load_data (load_data)
  );

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state       <= IDLE;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= 32'h0;
      rbuf        <= 32'h0;
      rdata_q     <= 32'h0;
      mem_idx_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
      adr_src_q   <= 1'b1;
    end else begin
      state     <= next_state;
      adr_src_q <= 1'b1;
      mem_we_q  <= (next_state == WR);
      if (accept) begin
        f3_q    <= i_Funct3;
        off_q   <= i_Addr[1:0];
        we_q    <= i_We;
        wdata_q <= i_wData;
        err_q   <= req_err;
        if (!req_err) mem_idx_q <= i_Addr[IDX_W+1:2];
      end
      if (state == RD) begin
        rbuf <= i_MemRData;
        if (!we_q) rdata_q <= load_data;
      end
      if (next_state == WR) mem_wdata_q <= (state == IDLE) ? i_wData : merged;
    end
  end

  assign o_Busy      = (state != IDLE);
  assign o_Done      = (state == RESP);
  assign o_Err       = (state == RESP) && err_q;
  assign o_rData     = rdata_q;
  assign o_MemAdrSrc = adr_src_q;
  assign o_MemAddr   = 32'(mem_idx_q);
  assign o_MemWE     = mem_we_q;
  assign o_MemWData  = mem_wdata_q;
  assign o_State     = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word memory; expected
// values are hand-computed from the preloaded memory image.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_Req, i_We;
  logic [2:0]  i_Funct3;
  logic [31:0] i_Addr, i_wData;
  logic        o_Busy, o_Done, o_Err, o_MemAdrSrc, o_MemWE;
  logic [31:0] o_rData, o_MemAddr, o_MemWData, i_MemRData;
  state_t      o_State;

  logic [31:0] mem [128];
  logic        preload;
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  int          n_assert = 0;
  int          n_fail   = 0;

  mem_access_ctrl #(.MEM_WORDS(128)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Req(i_Req), .i_We(i_We),
    .i_Funct3(i_Funct3), .i_Addr(i_Addr), .i_wData(i_wData),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Err(o_Err), .o_rData(o_rData),
    .o_MemAdrSrc(o_MemAdrSrc), .o_MemAddr(o_MemAddr), .o_MemWE(o_MemWE),
    .o_MemWData(o_MemWData), .i_MemRData(i_MemRData), .o_State(o_State)
  );

  // clock / memory model
  always #5 i_Clk = ~i_Clk;

  assign i_MemRData = mem[o_MemAddr[6:0]];

  always @(posedge i_Clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[7'h04] <= 32'h0000_0013;
      mem[7'h40] <= 32'h80FF_7F01;
      mem[7'h41] <= 32'h1122_3344;
      mem[7'h42] <= 32'hCAFE_BABE;
    end else if (o_MemWE) begin
      mem[o_MemAddr[6:0]] <= o_MemWData;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // following idle cycle so consecutive calls run back to back.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err, input int exp_wes,
                        input logic [31:0] exp_rd);
    int lat;
    int wes;
    logic err_seen;
    lat = 0; wes = 0; err_seen = 1'b0;
    exp_q.push_back(exp_rd);
    i_Req = 1'b1; i_We = we; i_Funct3 = f3; i_Addr = addr; i_wData = wd;
    @(posedge i_Clk); #1;
    i_Req = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge i_Clk);
      if (o_MemWE) wes++;
      if (o_Done) begin
        lat = cyc;
        err_seen = o_Err;
        check({tag, "_rdata"}, o_rData, exp_q.pop_front());
        break;
      end
    end
    if (lat == 0) void'(exp_q.pop_front());
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'b0, err_seen}, {31'b0, exp_err});
    check({tag, "_we_cycles"}, 32'(wes), 32'(exp_wes));
    @(negedge i_Clk);
    check({tag, "_busy_after"}, {31'b0, o_Busy}, 32'h0);
  endtask

  initial begin
    int dones, wes;
    i_Reset = 1'b0; i_Req = 1'b0; i_We = 1'b0; i_Funct3 = 3'b000;
    i_Addr = 32'h0; i_wData = 32'h0; preload = 1'b1;
    repeat (3) @(negedge i_Clk);
    preload = 1'b0;

    check("rst_busy",   {31'b0, o_Busy}, 32'h0);
    check("rst_done",   {31'b0, o_Done}, 32'h0);
    check("rst_err",    {31'b0, o_Err}, 32'h0);
    check("rst_we",     {31'b0, o_MemWE}, 32'h0);
    check("rst_adrsrc", {31'b0, o_MemAdrSrc}, 32'h1);
    check("rst_rdata",  o_rData, 32'h0);
    check("rst_addr",   o_MemAddr, 32'h0);
    check("rst_wdata",  o_MemWData, 32'h0);
    check("rst_state",  32'(o_State), 32'(IDLE));
    i_Reset = 1'b1;
    @(negedge i_Clk);

    // loads with sign/zero extension from word 0x40 = 0x80FF7F01
    run_op("lb_102",  1'b0, F3_B,  32'h102, 32'h0, 2, 1'b0, 0, 32'hFFFF_FFFF);
    run_op("lbu_102", 1'b0, F3_BU, 32'h102, 32'h0, 2, 1'b0, 0, 32'h0000_00FF);
    run_op("lh_102",  1'b0, F3_H,  32'h102, 32'h0, 2, 1'b0, 0, 32'hFFFF_80FF);
    run_op("lhu_100", 1'b0, F3_HU, 32'h100, 32'h0, 2, 1'b0, 0, 32'h0000_7F01);
    run_op("lb_101",  1'b0, F3_B,  32'h101, 32'h0, 2, 1'b0, 0, 32'h0000_007F);
    last_rd = 32'h0000_007F;

    // sub-word read-modify-write and full-word stores
    run_op("sb_105", 1'b1, F3_B, 32'h105, 32'h0000_00AB, 3, 1'b0, 1, last_rd);
    check("sb_mem", mem[7'h41], 32'h1122_AB44);
    run_op("lw_104", 1'b0, F3_W, 32'h104, 32'h0, 2, 1'b0, 0, 32'h1122_AB44);
    last_rd = 32'h1122_AB44;
    run_op("sh_106", 1'b1, F3_H, 32'h106, 32'h1234_5678, 3, 1'b0, 1, last_rd);
    check("sh_mem", mem[7'h41], 32'h5678_AB44);
    run_op("sw_10c", 1'b1, F3_W, 32'h10C, 32'hDEAD_BEEF, 2, 1'b0, 1, last_rd);
    check("sw_mem", mem[7'h43], 32'hDEAD_BEEF);
    run_op("lw_10c", 1'b0, F3_W, 32'h10C, 32'h0, 2, 1'b0, 0, 32'hDEAD_BEEF);
    last_rd = 32'hDEAD_BEEF;

    // error cases: rdata held, no write
    run_op("sw_prot", 1'b1, F3_W, 32'h010, 32'h5555_5555, 1, 1'b1, 0, last_rd);
    check("sw_prot_mem", mem[7'h04], 32'h0000_0013);
    run_op("lw_range", 1'b0, F3_W, 32'h200, 32'h0, 1, 1'b1, 0, last_rd);
    run_op("bad_f3",   1'b0, 3'b011, 32'h100, 32'h0, 1, 1'b1, 0, last_rd);
    run_op("sb_prot",  1'b1, F3_B, 32'h0FC, 32'h0000_0077, 1, 1'b1, 0, last_rd);
    run_op("su_f3",    1'b1, F3_BU, 32'h108, 32'h0000_0077, 1, 1'b1, 0, last_rd);
    check("su_f3_mem", mem[7'h42], 32'hCAFE_BABE);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    run_op("lw_mis", 1'b0, F3_W, 32'h102, 32'h0, 1, 1'b1, 0, last_rd);
`else
    run_op("lw_mis", 1'b0, F3_W, 32'h102, 32'h0, 2, 1'b0, 0, 32'h80FF_7F01);
    last_rd = 32'h80FF_7F01;
`endif

    // request while busy: stray SW held through RD and RESP must be dropped
    i_Req = 1'b1; i_We = 1'b0; i_Funct3 = F3_W; i_Addr = 32'h104; i_wData = 32'h0;
    @(posedge i_Clk); #1;
    i_Req = 1'b0;
    dones = 0; wes = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge i_Clk);
      if (o_Done) begin
        dones++;
        check("busy_rdata", o_rData, 32'h5678_AB44);
      end
      if (o_MemWE) wes++;
      if (cyc == 1) begin
        check("busy_hi", {31'b0, o_Busy}, 32'h1);
        i_Req = 1'b1; i_We = 1'b1; i_Funct3 = F3_W; i_Addr = 32'h110; i_wData = 32'h55;
      end
      if (cyc == 3) begin
        check("busy_lo", {31'b0, o_Busy}, 32'h0);
        i_Req = 1'b0;
      end
    end
    check("busy_dones", 32'(dones), 32'h1);
    check("busy_we", 32'(wes), 32'h0);
    check("busy_mem", mem[7'h44], 32'h0);
    last_rd = 32'h5678_AB44;

    // reset during the WR cycle of an SH to word 0x42
    i_Req = 1'b1; i_We = 1'b1; i_Funct3 = F3_H; i_Addr = 32'h10A; i_wData = 32'h0000_9999;
    @(posedge i_Clk); #1;
    i_Req = 1'b0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    check("mid_we_pre", {31'b0, o_MemWE}, 32'h1);
    i_Reset = 1'b0;
    #1;
    check("mid_we",     {31'b0, o_MemWE}, 32'h0);
    check("mid_busy",   {31'b0, o_Busy}, 32'h0);
    check("mid_done",   {31'b0, o_Done}, 32'h0);
    check("mid_err",    {31'b0, o_Err}, 32'h0);
    check("mid_rdata",  o_rData, 32'h0);
    check("mid_addr",   o_MemAddr, 32'h0);
    check("mid_wdata",  o_MemWData, 32'h0);
    check("mid_adrsrc", {31'b0, o_MemAdrSrc}, 32'h1);
    @(negedge i_Clk);
    i_Reset = 1'b1;
    check("mid_mem", mem[7'h42], 32'hCAFE_BABE);
    run_op("lw_after_rst", 1'b0, F3_W, 32'h108, 32'h0, 2, 1'b0, 0, 32'hCAFE_BABE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
